// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stream_pkg
//  Description : Shared helpers for the stream FIFO: the occupancy counter
//                width and the ring-pointer increment that wraps by explicit
//                compare, so any DEPTH (not only powers of two) works.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a ring pointer, wrapping to 0 after depth-1.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_mem
//  Description : Storage array for stream_fifo. Registered write,
//                combinational read, asynchronous active-low clear of every
//                entry to zero.
//  Ports       : clk    - clock
//                reset  - asynchronous active-low clear
//                we     - write enable
//                waddr  - write address
//                wdata  - write data
//                raddr  - read address
//                rdata  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo
//  Description : Synchronous FIFO with valid/ready handshakes on both sides.
//                in_ready depends only on the stored count, so there is no
//                combinational path from out_ready back to the producer.
//                Optional feature macro: STREAM_FIFO_BYPASS_EN - when the
//                queue is empty and both sides handshake, the input word is
//                forwarded combinationally and never stored.
//  Ports       : clk       - clock
//                reset     - asynchronous active-low reset
//                in_valid  - producer has data
//                in_data   - producer data
//                in_ready  - FIFO accepts a push this cycle
//                out_valid - FIFO presents valid data
//                out_data  - head-of-queue data
//                out_ready - consumer accepts data
//                count     - number of stored entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo
  import stream_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_rdata;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_store;
  logic             w_deq;

`ifdef STREAM_FIFO_BYPASS_EN
  // Gated by reset so nothing is presented while the FIFO is held in reset.
  assign w_bypass = reset & (r_count == '0) & in_valid & out_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0) | w_bypass;
  assign out_data  = w_bypass ? in_data : w_rdata;
  assign count     = r_count;

  assign w_push  = in_valid & in_ready;
  assign w_pop   = out_valid & out_ready;
  // A bypassed word is both pushed and popped without touching storage.
  assign w_store = w_push & ~w_bypass;
  assign w_deq   = w_pop & ~w_bypass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= AW'(ptr_inc(int'(r_wr_ptr), DEPTH));
      end
      if (w_deq) begin
        r_rd_ptr <= AW'(ptr_inc(int'(r_rd_ptr), DEPTH));
      end
      case ({w_store, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (w_store),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

endmodule
`default_nettype wire
